// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: mode/sequencing controller for the 5-stage mips32 pipeline.
// Streams program words into instruction memory (LOAD), runs the pipeline with
// branch squash (RUN), drains on HALT (DRAIN) and parks (HALTED).
module pipe_run_ctrl #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DRAIN_CYC = 4,
   parameter int unsigned FLUSH_CYC = 2,
   parameter logic [5:0]  HALT_OP   = 6'b111111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              run_req,
   input  logic              prog_valid,
   input  logic              prog_last,
   input  logic [31:0]       prog_data,
   output logic              prog_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       if_ir,
   input  logic              ex_sel,
   output logic              pc_clr,
   output logic              fetch_en,
   output logic              pipe_en,
   output logic              flush,
   output logic [ADDR_W:0]   prog_len,
   output logic [2:0]        state_o,
   output logic              ovf_err
);

   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned FCNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
   localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   state_t              state, state_d;
   logic [PTR_W-1:0]    ptr, ptr_d;
   logic [PTR_W-1:0]    prog_len_d;
   logic                ovf_d;
   logic [FCNT_W-1:0]   fcnt, fcnt_d;
   logic [DCNT_W-1:0]   dcnt, dcnt_d;
   logic                pc_clr_d, fetch_en_d, pipe_en_d, flush_d;
   logic                xfer;
   logic                halt_seen;
   logic                unused_ir;

   // Write port decoded from state and pointer; a reset cycle never writes.
   assign prog_ready = (state == ST_LOAD) && !ptr[ADDR_W] && !rst;
   assign xfer       = prog_valid && prog_ready;
   assign imem_we    = xfer;
   assign imem_waddr = ptr[ADDR_W-1:0];
   assign imem_wdata = prog_data;
   assign state_o    = state;

   // HALT only counts on a right-path slot.
   assign halt_seen  = (if_ir[31:26] == HALT_OP) && !flush;
   assign unused_ir  = ^if_ir[25:0];

   // Next-state and next-value of every registered output.
   always_comb begin
      state_d    = state;
      ptr_d      = ptr;
      prog_len_d = prog_len;
      ovf_d      = ovf_err;
      fcnt_d     = '0;
      dcnt_d     = '0;
      pc_clr_d   = 1'b0;
      fetch_en_d = 1'b0;
      pipe_en_d  = 1'b0;
      flush_d    = 1'b0;
      case (state)
         ST_IDLE, ST_HALTED: begin
            if (load_req) begin
               state_d    = ST_LOAD;
               ptr_d      = '0;
               prog_len_d = '0;
               ovf_d      = 1'b0;
            end else if (run_req) begin
               state_d  = ST_RUN;
               pc_clr_d = 1'b1;
            end else if (state == ST_IDLE) begin
               pc_clr_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               ptr_d      = ptr + PTR_W'(1);
               prog_len_d = ptr + PTR_W'(1);
               if (prog_last) begin
                  state_d  = ST_IDLE;
                  pc_clr_d = 1'b1;
               end
            end else if (prog_valid && ptr[ADDR_W]) begin
               ovf_d = 1'b1;
               if (prog_last) begin
                  state_d  = ST_IDLE;
                  pc_clr_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (ex_sel) begin
               fcnt_d = FCNT_W'(FLUSH_CYC);
            end else if (fcnt != '0) begin
               fcnt_d = fcnt - FCNT_W'(1);
            end
            if (halt_seen) begin
               state_d   = ST_DRAIN;
               pipe_en_d = 1'b1;
               fcnt_d    = '0;
            end else begin
               fetch_en_d = 1'b1;
               pipe_en_d  = 1'b1;
               flush_d    = (fcnt_d != '0);
            end
         end
         ST_DRAIN: begin
            if (dcnt == DCNT_W'(DRAIN_CYC - 1)) begin
               state_d = ST_HALTED;
            end else begin
               dcnt_d    = dcnt + DCNT_W'(1);
               pipe_en_d = 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            pc_clr_d = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         prog_len <= '0;
         ovf_err  <= 1'b0;
         fcnt     <= '0;
         dcnt     <= '0;
         pc_clr   <= 1'b1;
         fetch_en <= 1'b0;
         pipe_en  <= 1'b0;
         flush    <= 1'b0;
      end else begin
         state    <= state_d;
         ptr      <= ptr_d;
         prog_len <= prog_len_d;
         ovf_err  <= ovf_d;
         fcnt     <= fcnt_d;
         dcnt     <= dcnt_d;
         pc_clr   <= pc_clr_d;
         fetch_en <= fetch_en_d;
         pipe_en  <= pipe_en_d;
         flush    <= flush_d;
      end
   end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb_pipe_run_ctrl: scoreboard bench for pipe_run_ctrl. Stimulus pushes
// expected writes and status snapshots; a negedge monitor pops and compares.
module tb_pipe_run_ctrl;

   localparam logic [2:0]  S_IDLE   = 3'd0;
   localparam logic [2:0]  S_LOAD   = 3'd1;
   localparam logic [2:0]  S_RUN    = 3'd2;
   localparam logic [2:0]  S_DRAIN  = 3'd3;
   localparam logic [2:0]  S_HALTED = 3'd4;
   localparam logic [31:0] HALT_W   = 32'hFC00_0000;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string       nm;
      bit          u2;
      logic [20:0] exp;
      logic [20:0] msk;
   } snap_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (default geometry)
   logic        rst = 1'b1, load_req = 1'b0, run_req = 1'b0;
   logic        prog_valid = 1'b0, prog_last = 1'b0, ex_sel = 1'b0;
   logic [31:0] prog_data = '0, if_ir = '0;
   logic        prog_ready, imem_we, pc_clr, fetch_en, pipe_en, flush, ovf_err;
   logic [9:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic [10:0] prog_len;
   logic [2:0]  state_o;

   // small instance (ADDR_W=2) for the overflow case
   logic        rst2 = 1'b1, load_req2 = 1'b0;
   logic        prog_valid2 = 1'b0, prog_last2 = 1'b0;
   logic [31:0] prog_data2 = '0;
   logic        prog_ready2, imem_we2, pc_clr2, fetch_en2, pipe_en2, flush2, ovf_err2;
   logic [1:0]  imem_waddr2;
   logic [31:0] imem_wdata2;
   logic [2:0]  prog_len2;
   logic [2:0]  state_o2;

   pipe_run_ctrl dut (
      .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req),
      .prog_valid(prog_valid), .prog_last(prog_last), .prog_data(prog_data),
      .prog_ready(prog_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .if_ir(if_ir), .ex_sel(ex_sel), .pc_clr(pc_clr),
      .fetch_en(fetch_en), .pipe_en(pipe_en), .flush(flush), .prog_len(prog_len),
      .state_o(state_o), .ovf_err(ovf_err)
   );

   pipe_run_ctrl #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst2), .load_req(load_req2), .run_req(1'b0),
      .prog_valid(prog_valid2), .prog_last(prog_last2), .prog_data(prog_data2),
      .prog_ready(prog_ready2), .imem_we(imem_we2), .imem_waddr(imem_waddr2),
      .imem_wdata(imem_wdata2), .if_ir(32'h0), .ex_sel(1'b0), .pc_clr(pc_clr2),
      .fetch_en(fetch_en2), .pipe_en(pipe_en2), .flush(flush2), .prog_len(prog_len2),
      .state_o(state_o2), .ovf_err(ovf_err2)
   );

   int    checks = 0;
   int    errors = 0;
   wr_t   wq[$];
   wr_t   wq2[$];
   snap_t sq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input bit u2, input int addr, input logic [31:0] data);
      wr_t w;
      w.addr = 10'(addr);
      w.data = data;
      if (u2) wq2.push_back(w);
      else    wq.push_back(w);
   endtask

   // pc: 0/1 expected value, 2 = not checked
   task automatic snap(input string nm, input bit u2, input logic [2:0] st, input int pc,
                       input logic fe, input logic pe, input logic fl, input logic rdy,
                       input logic we, input int plen, input logic ovf);
      snap_t s;
      s.nm  = nm;
      s.u2  = u2;
      s.exp = {st, (pc == 1), fe, pe, fl, rdy, we, ovf, 11'(plen)};
      s.msk = {3'b111, (pc != 2), 6'b111111, 11'h7FF};
      sq.push_back(s);
   endtask

   // Monitor: compares every write strobe and every queued snapshot.
   always @(negedge clk) begin
      wr_t         w;
      snap_t       s;
      logic [20:0] act;
      if (imem_we === 1'b1) begin
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", imem_waddr, imem_wdata);
         end else begin
            w = wq.pop_front();
            if ({imem_waddr, imem_wdata} !== {w.addr, w.data}) begin
               errors++;
               $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                        imem_waddr, imem_wdata, w.addr, w.data);
            end
         end
      end
      if (imem_we2 === 1'b1) begin
         checks++;
         if (wq2.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write2 addr=%h data=%h", imem_waddr2, imem_wdata2);
         end else begin
            w = wq2.pop_front();
            if ({8'h00, imem_waddr2, imem_wdata2} !== {w.addr, w.data}) begin
               errors++;
               $display("FAIL write2 got addr=%h data=%h want addr=%h data=%h",
                        imem_waddr2, imem_wdata2, w.addr, w.data);
            end
         end
      end
      while (sq.size() > 0) begin
         s = sq.pop_front();
         if (s.u2)
            act = {state_o2, pc_clr2, fetch_en2, pipe_en2, flush2, prog_ready2, imem_we2,
                   ovf_err2, 11'(prog_len2)};
         else
            act = {state_o, pc_clr, fetch_en, pipe_en, flush, prog_ready, imem_we,
                   ovf_err, prog_len};
         checks++;
         if ((act & s.msk) !== (s.exp & s.msk)) begin
            errors++;
            $display("FAIL %s got=%h want=%h mask=%h {st,pc,fe,pe,fl,rdy,we,ovf,len}",
                     s.nm, act, s.exp, s.msk);
         end
      end
   end

   initial begin
      // reset held two cycles
      tick(); tick();
      snap("reset", 0, S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
      snap("reset2", 1, S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0; rst2 = 1'b0;

      // gapped 3-word load
      tick(); load_req = 1'b1;
      tick(); load_req = 1'b0;
      snap("load_entry", 0, S_LOAD, 2, 0, 0, 0, 1, 0, 0, 0);
      tick(); prog_valid = 1'b1; prog_data = 32'h2001_0005; push_wr(0, 0, 32'h2001_0005);
      snap("load_xfer0", 0, S_LOAD, 2, 0, 0, 0, 1, 1, 0, 0);
      tick(); prog_valid = 1'b0;
      snap("load_gap1", 0, S_LOAD, 2, 0, 0, 0, 1, 0, 1, 0);
      tick(); prog_valid = 1'b1; prog_data = 32'h2002_0003; push_wr(0, 1, 32'h2002_0003);
      tick(); prog_valid = 1'b0;
      tick();
      tick(); prog_valid = 1'b1; prog_data = HALT_W; prog_last = 1'b1; push_wr(0, 2, HALT_W);
      tick(); prog_valid = 1'b0; prog_last = 1'b0;
      snap("load_done", 0, S_IDLE, 1, 0, 0, 0, 0, 0, 3, 0);

      // run then HALT fetched
      tick(); run_req = 1'b1;
      tick(); run_req = 1'b0;
      snap("run_entry", 0, S_RUN, 1, 0, 0, 0, 0, 0, 3, 0);
      tick();
      snap("run_fetch", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);
      tick(); tick();
      tick(); if_ir = HALT_W;
      snap("halt_cycle", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);
      tick(); if_ir = 32'h0;
      snap("drain_first", 0, S_DRAIN, 2, 0, 1, 0, 0, 0, 3, 0);
      tick(); tick(); tick();
      snap("drain_last", 0, S_DRAIN, 2, 0, 1, 0, 0, 0, 3, 0);
      tick();
      snap("halted", 0, S_HALTED, 2, 0, 0, 0, 0, 0, 3, 0);

      // re-run, branch flush, restart, HALT ignored while flushing
      tick(); run_req = 1'b1;
      tick(); run_req = 1'b0;
      snap("rerun_entry", 0, S_RUN, 1, 0, 0, 0, 0, 0, 3, 0);
      tick(); ex_sel = 1'b1;
      snap("pre_flush", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);
      tick(); ex_sel = 1'b0;
      snap("flush_c1", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick();
      snap("flush_c2", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick();
      snap("flush_end", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);
      tick(); ex_sel = 1'b1;
      tick(); ex_sel = 1'b0;
      snap("flush_b1", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick(); ex_sel = 1'b1;
      snap("flush_b2", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick(); ex_sel = 1'b0; if_ir = HALT_W;
      snap("flush_ext1", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick();
      snap("flush_ext2", 0, S_RUN, 0, 1, 1, 1, 0, 0, 3, 0);
      tick(); if_ir = 32'h0; load_req = 1'b1;
      snap("halt_ignored", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);
      tick(); load_req = 1'b0;
      snap("req_ignored_run", 0, S_RUN, 0, 1, 1, 0, 0, 0, 3, 0);

      // reset mid-run, simultaneous requests, reset mid-load
      rst = 1'b1;
      tick(); rst = 1'b0; load_req = 1'b1; run_req = 1'b1;
      snap("rst_in_run", 0, S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);
      tick(); load_req = 1'b0; run_req = 1'b0;
      prog_valid = 1'b1; prog_data = 32'h1111_1111; push_wr(0, 0, 32'h1111_1111);
      snap("load_wins", 0, S_LOAD, 2, 0, 0, 0, 1, 1, 0, 0);
      tick(); rst = 1'b1; prog_data = 32'h2222_2222;
      snap("rst_in_load", 0, S_LOAD, 2, 0, 0, 0, 0, 0, 1, 0);
      tick(); rst = 1'b0; prog_valid = 1'b0;
      snap("after_rst_load", 0, S_IDLE, 1, 0, 0, 0, 0, 0, 0, 0);

      // overflow on the 4-deep instance
      tick(); load_req2 = 1'b1;
      tick(); load_req2 = 1'b0; prog_valid2 = 1'b1;
      prog_data2 = 32'hA0; push_wr(1, 0, 32'hA0);
      tick(); prog_data2 = 32'hA1; push_wr(1, 1, 32'hA1);
      tick(); prog_data2 = 32'hA2; push_wr(1, 2, 32'hA2);
      tick(); prog_data2 = 32'hA3; push_wr(1, 3, 32'hA3);
      snap("ovf_last_fit", 1, S_LOAD, 2, 0, 0, 0, 1, 1, 3, 0);
      tick(); prog_data2 = 32'hA4; prog_last2 = 1'b1;
      snap("ovf_full", 1, S_LOAD, 2, 0, 0, 0, 0, 0, 4, 0);
      tick(); prog_valid2 = 1'b0; prog_last2 = 1'b0;
      snap("ovf_done", 1, S_IDLE, 1, 0, 0, 0, 0, 0, 4, 1);

      tick(); tick();
      @(negedge clk); #1;
      checks++;
      if (wq.size() != 0 || wq2.size() != 0 || sq.size() != 0) begin
         errors++;
         $display("FAIL queues_drained got=%0d/%0d/%0d want=0/0/0",
                  wq.size(), wq2.size(), sq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
